// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_tx_arbiter_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Width of a requester index (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the grant-idle counter; a disabled timeout still gets 1 bit.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signal bundle for the UART TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]                               req_i;
    logic [N_REQ-1:0]                               valid_i;
    logic [uart_tx_arbiter_pkg::BYTE_W*N_REQ-1:0]   data_i;
    logic [N_REQ-1:0]                               last_i;
    logic [N_REQ-1:0]                               ready_o;
    logic [N_REQ-1:0]                               gnt_o;
    logic [uart_tx_arbiter_pkg::BYTE_W-1:0]         tx_data_o;
    logic                                           tx_valid_o;
    logic                                           tx_ready_i;
    logic                                           busy_o;

    // Requesters plus UART core side.
    modport master (
        output req_i, valid_i, data_i, last_i, tx_ready_i,
        input  ready_o, gnt_o, tx_data_o, tx_valid_o, busy_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, valid_i, data_i, last_i, tx_ready_i,
        output ready_o, gnt_o, tx_data_o, tx_valid_o, busy_o
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational one-hot picker: first set request after the last-grant pointer.
// With UART_ARB_FIXED_PRIO_EN defined the pointer is pinned to N_REQ-1 so the
// lowest requesting index always wins.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             any_o,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0] win_idx_o
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    logic [N_REQ-1:0] oh;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;

`ifdef UART_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;
    assign ptr         = IDX_W'(N_REQ - 1);
`else
    assign ptr         = last_i;
`endif

    // Scan (ptr+1 .. ptr+N_REQ) mod N_REQ and keep the first hit.
    always_comb begin
        found = 1'b0;
        oh    = '0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(N_REQ));
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                oh[cand] = 1'b1;
                idx      = cand;
            end
        end
    end

    assign any_o     = found;
    assign win_oh_o  = oh;
    assign win_idx_o = idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level arbiter sharing one UART TX byte port among N_REQ requesters.
// Round-robin by default; define UART_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, pointer frozen). One registered byte stage feeds the core.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned     IDX_W  = idx_width(N_REQ);
    localparam int unsigned     TO_W   = cnt_width(TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    arb_state_e        state_q,    state_d;
    logic [N_REQ-1:0]  gnt_q,      gnt_d;
    logic [IDX_W-1:0]  widx_q,     widx_d;
    logic [IDX_W-1:0]  last_q,     last_d;
    logic [TO_W-1:0]   to_cnt_q,   to_cnt_d;
    logic [BYTE_W-1:0] tx_data_q,  tx_data_d;
    logic              tx_valid_q, tx_valid_d;

    logic              pick_any;
    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  ready_c;
    logic              xfer_c;
    logic              timeout_c;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (bus.req_i),
        .last_i    (last_q),
        .any_o     (pick_any),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx)
    );

    // Next-state: grant/release, idle timeout, output byte stage.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        widx_d     = widx_q;
        last_d     = last_q;
        to_cnt_d   = to_cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ready_c    = '0;
        xfer_c     = 1'b0;
        timeout_c  = 1'b0;

        // Drain; a same-cycle transfer below overrides this.
        if (tx_valid_q && bus.tx_ready_i) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_GRANT;
                    gnt_d    = pick_oh;
                    widx_d   = pick_idx;
                    to_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                ready_c[widx_q] = bus.req_i[widx_q] && (!tx_valid_q || bus.tx_ready_i);
                xfer_c          = ready_c[widx_q] && bus.valid_i[widx_q];
                timeout_c       = (TIMEOUT != 0) && (to_cnt_q == TO_MAX);

                if (xfer_c) begin
                    tx_data_d  = bus.data_i[BYTE_W*widx_q +: BYTE_W];
                    tx_valid_d = 1'b1;
                    to_cnt_d   = '0;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d   = to_cnt_q + TO_W'(1);
                end

                // Release does not wait for the output stage to drain.
                if ((xfer_c && bus.last_i[widx_q]) || !bus.req_i[widx_q] || timeout_c) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
                    last_d  = widx_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            widx_q     <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            to_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            widx_q     <= widx_d;
            last_q     <= last_d;
            to_cnt_q   <= to_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.ready_o    = ready_c;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = tx_valid_q;
    assign bus.busy_o     = (state_q != ST_IDLE) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=2, TIMEOUT=8).
// Accepted bytes go into a scoreboard queue; the output monitor pops and
// compares each byte the UART side consumes.
module tb_uart_tx_arbiter;

    localparam int unsigned TB_N   = 2;
    localparam int unsigned TB_TO  = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    logic [7:0] exp_q[$];

    uart_tx_arbiter_if #(.N_REQ(TB_N)) bus ();

    uart_tx_arbiter #(
        .N_REQ   (TB_N),
        .TIMEOUT (TB_TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: a byte leaves when tx_valid && tx_ready at the next edge.
    always @(negedge clk) begin
        if (!rst && bus.tx_valid_o && bus.tx_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL tx_unexpected: got %h, scoreboard empty", bus.tx_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.tx_data_o !== e)
                    $display("FAIL tx_data: got %h, required %h", bus.tx_data_o, e);
                else
                    passes++;
            end
        end
    end

    // Present one byte on requester r until accepted; returns at posedge+1.
    task automatic send_byte(input int r, input logic [7:0] b, input logic lst);
        bit ok;
        ok = 1'b0;
        bus.valid_i[r]       = 1'b1;
        bus.data_i[8*r +: 8] = b;
        bus.last_i[r]        = lst;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready_o[r]) begin
                exp_q.push_back(b);
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.valid_i[r] = 1'b0;
        bus.last_i[r]  = 1'b0;
        checks++;
        if (!ok) $display("FAIL send_accept: req %0d byte %h accepted=0, required 1", r, b);
        else     passes++;
    endtask

    // Drive-only reset sequence; in-flight expectations are discarded.
    task automatic do_reset();
        rst            = 1'b1;
        bus.req_i      = '0;
        bus.valid_i    = '0;
        bus.last_i     = '0;
        bus.data_i     = '0;
        bus.tx_ready_i = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        bus.tx_ready_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.req_i      = 2'b11;
        bus.valid_i    = 2'b11;
        bus.last_i     = '0;
        bus.data_i     = 16'hBEEF;
        bus.tx_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.gnt_o !== 2'b00) $display("FAIL rst_gnt: got %b, required 00", bus.gnt_o); else passes++;
        checks++; if (bus.ready_o !== 2'b00) $display("FAIL rst_ready: got %b, required 00", bus.ready_o); else passes++;
        checks++; if (bus.tx_valid_o !== 1'b0) $display("FAIL rst_tx_valid: got %b, required 0", bus.tx_valid_o); else passes++;
        checks++; if (bus.tx_data_o !== 8'h00) $display("FAIL rst_tx_data: got %h, required 00", bus.tx_data_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy_o); else passes++;
        do_reset();
    endtask

    task automatic test_single_message();
        logic [7:0] msg [3];
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
        do_reset();
        bus.req_i = 2'b01;
        @(negedge clk);
        checks++; if (bus.gnt_o !== 2'b00) $display("FAIL single_gnt_early: got %b, required 00", bus.gnt_o); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.gnt_o !== 2'b01) $display("FAIL single_gnt: got %b, required 01", bus.gnt_o); else passes++;
        for (int i = 0; i < 3; i++) begin
            send_byte(0, msg[i], (i == 2));
            checks++;
            if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== msg[i])
                $display("FAIL single_tx_seq: got valid=%b data=%h, required valid=1 data=%h",
                         bus.tx_valid_o, bus.tx_data_o, msg[i]);
            else passes++;
        end
        checks++; if (bus.gnt_o !== 2'b00) $display("FAIL single_release: got %b, required 00", bus.gnt_o); else passes++;
        bus.req_i = 2'b00;
        drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int         gap;
            int         r;
            logic [1:0] e;
            gap = 0;
            r   = i % 2;
            e   = (r == 0) ? 2'b01 : 2'b10;
            while (bus.gnt_o == 2'b00 && gap < 20) begin @(posedge clk); #1; gap++; end
            checks++; if (bus.gnt_o !== e) $display("FAIL rr_order[%0d]: got %b, required %b", i, bus.gnt_o, e); else passes++;
            if (i > 0) begin
                checks++; if (gap != 1) $display("FAIL rr_gap[%0d]: got %0d idle cycles, required 1", i, gap); else passes++;
            end
            send_byte(r, 8'h10 + 8'(i), 1'b1);
            checks++; if (bus.gnt_o !== 2'b00) $display("FAIL rr_release[%0d]: got %b, required 00", i, bus.gnt_o); else passes++;
        end
        bus.req_i = 2'b00;
        drain();
    endtask

    task automatic test_fixed_prio();
        do_reset();
        bus.req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = 0;
            while (bus.gnt_o == 2'b00 && gap < 20) begin @(posedge clk); #1; gap++; end
            checks++; if (bus.gnt_o !== 2'b01) $display("FAIL fp_order[%0d]: got %b, required 01", i, bus.gnt_o); else passes++;
            send_byte(0, 8'h20 + 8'(i), 1'b1);
        end
        bus.req_i = 2'b00;
        drain();
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        bus.tx_ready_i = 1'b0;
        bus.req_i      = 2'b01;
        @(posedge clk); #1;
        send_byte(0, 8'h55, 1'b0);
        bus.valid_i          = 2'b11;
        bus.data_i           = 16'hEEAA;
        bus.last_i           = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.tx_data_o !== 8'h55) $display("FAIL bp_hold_data[%0d]: got %h, required 55", i, bus.tx_data_o); else passes++;
            checks++; if (bus.tx_valid_o !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b, required 1", i, bus.tx_valid_o); else passes++;
            checks++; if (bus.ready_o !== 2'b00) $display("FAIL bp_ready[%0d]: got %b, required 00", i, bus.ready_o); else passes++;
            @(posedge clk); #1;
        end
        bus.tx_ready_i = 1'b1;
        @(negedge clk);
        ok = (bus.ready_o === 2'b01);
        if (ok) exp_q.push_back(8'hAA);
        checks++; if (!ok) $display("FAIL bp_resume_ready: got %b, required 01", bus.ready_o); else passes++;
        @(posedge clk); #1;
        bus.valid_i = 2'b00;
        bus.last_i  = 2'b00;
        checks++;
        if (bus.tx_data_o !== 8'hAA || bus.tx_valid_o !== 1'b1)
            $display("FAIL bp_next_byte: got valid=%b data=%h, required valid=1 data=aa", bus.tx_valid_o, bus.tx_data_o);
        else passes++;
        bus.req_i = 2'b00;
        drain();
    endtask

    task automatic test_timeout();
        int hi;
        do_reset();
        bus.req_i = 2'b11;
        @(posedge clk); #1;
        checks++; if (bus.gnt_o !== 2'b01) $display("FAIL to_first_gnt: got %b, required 01", bus.gnt_o); else passes++;
        hi = 0;
        while (bus.gnt_o == 2'b01 && hi < 40) begin hi++; @(posedge clk); #1; end
        checks++; if (hi != int'(TB_TO) + 1) $display("FAIL to_hold: got %0d grant cycles, required %0d", hi, TB_TO + 1); else passes++;
        checks++; if (bus.gnt_o !== 2'b00) $display("FAIL to_release: got %b, required 00", bus.gnt_o); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.gnt_o !== 2'b10) $display("FAIL to_next_gnt: got %b, required 10", bus.gnt_o); else passes++;
        bus.req_i = 2'b00;
        drain();
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        bus.req_i = 2'b01;
        @(posedge clk); #1;
        send_byte(0, 8'h31, 1'b1);
        bus.req_i = 2'b10;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (bus.gnt_o !== 2'b10) $display("FAIL mid_gnt1: got %b, required 10", bus.gnt_o); else passes++;
        bus.tx_ready_i = 1'b0;
        send_byte(1, 8'h62, 1'b0);
        #3 rst = 1'b1;
        #1;
        exp_q.delete();
        checks++; if (bus.gnt_o !== 2'b00) $display("FAIL mid_rst_gnt: got %b, required 00", bus.gnt_o); else passes++;
        checks++; if (bus.tx_valid_o !== 1'b0) $display("FAIL mid_rst_valid: got %b, required 0", bus.tx_valid_o); else passes++;
        checks++; if (bus.tx_data_o !== 8'h00) $display("FAIL mid_rst_data: got %h, required 00", bus.tx_data_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", bus.busy_o); else passes++;
        checks++; if (bus.ready_o !== 2'b00) $display("FAIL mid_rst_ready: got %b, required 00", bus.ready_o); else passes++;
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.req_i      = 2'b11;
        bus.tx_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.gnt_o !== 2'b01) $display("FAIL mid_post_winner: got %b, required 01", bus.gnt_o); else passes++;
        send_byte(0, 8'h7E, 1'b1);
        bus.req_i = 2'b00;
        drain();
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_i      = '0;
        bus.valid_i    = '0;
        bus.last_i     = '0;
        bus.data_i     = '0;
        bus.tx_ready_i = 1'b1;
        test_reset();
        test_single_message();
`ifdef UART_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_backpressure();
        test_timeout();
        test_reset_mid_message();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
